// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART byte receiver.
// One-hot state encoding, data width and baud divider helper.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_e;

    function automatic int calc_bit_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is a parameter so idle-high lines stay quiet through reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: mid-bit sampling after a synchronized start edge.
// Emits one-cycle rx_valid or frame_err pulses per completed frame.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD);
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic rx_s2;
    logic rx_s3_q, rx_s3_d;
    logic start_edge;

    state_e            state_q, state_d;
    logic [CW-1:0]     baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s2)
    );

    assign rx_s3_d    = rx_s2;
    assign start_edge = rx_s3_q && !rx_s2;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                end
            end
            START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = rx_s2 ? IDLE : DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d         = '0;
                    shift_d[bit_idx_q] = rx_s2;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (rx_s2) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_s3_q    <= 1'b1;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_s3_q    <= rx_s3_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx at 10 clocks per bit.
// Stimulus queues expected pulses; a negedge monitor checks them.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_out  = 1'b0;

    uart_byte_rx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Frame starts after edge E0; stop bit is sampled at E0+98.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        exp_t e;
        bits = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        e.err  = !stop;
        e.data = stop ? b : last_good;
        e.t    = cyc + 98;
        if (stop) last_good = b;
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            rx = bits[i];
            repeat (9) @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_out <= 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                checks++;
                if (rx_valid && frame_err) begin
                    errors++;
                    $display("FAIL both_pulses: valid=%b err=%b required one",
                             rx_valid, frame_err);
                end else if (prev_out) begin
                    errors++;
                    $display("FAIL double_pulse: at cycle %0d required gap", cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: err=%b data=%h at %0d required none",
                             frame_err, rx_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (frame_err != e.err || rx_data != e.data || cyc != e.t) begin
                        errors++;
                        $display("FAIL frame: err=%b data=%h t=%0d required err=%b data=%h t=%0d",
                                 frame_err, rx_data, cyc, e.err, e.data, e.t);
                    end
                end
            end
            prev_out <= rx_valid || frame_err;
        end
    end

    initial begin
        int e0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        send_frame(8'h73, 1'b1);
        repeat (20) @(posedge clk);

        send_frame(8'h55, 1'b0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("break_no_retrigger_busy", int'(busy), 0);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);

        send_frame(8'h73, 1'b1);
        send_frame(8'h74, 1'b1);
        send_frame(8'h61, 1'b1);
        send_frame(8'h74, 1'b1);
        send_frame(8'h65, 1'b1);
        repeat (20) @(posedge clk);

        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_high", int'(busy), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_low", int'(busy), 0);
        repeat (10) @(posedge clk);
        send_frame(8'h41, 1'b1);
        repeat (20) @(posedge clk);

        @(posedge clk);
        #1 rx = 1'b0;
        e0 = cyc;
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (45) @(posedge clk);
        #1 rst = 1'b1;
        chk("abort_in_data_bit4", cyc - e0, 55);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rx_data", int'(rx_data), 0);
        repeat (80) @(posedge clk);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(posedge clk);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("pending_expected", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
